// File: rtl/argmax_feeder.sv
// argmax_feeder
//   Streams num_vals signed 16-bit elements from a result buffer into an
//   external 4-input argmax comparator, four elements per comparator trigger,
//   and reports the comparator's final index/maximum with a one-cycle done.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               run request (honoured in IDLE only)
//   num_vals            element count, 1..252 accepted
//   base_addr           buffer address of element 1
//   mem_rd, mem_addr    read strobe/address (data returns one cycle later)
//   mem_rdata           signed read data
//   cmp_reset           comparator clear (reset or CLEAR state)
//   cmp_enable          comparator enable (TRIG and EVAL)
//   cmp_trig            comparator trigger (TRIG)
//   cmp_in1..cmp_in4    comparator operands, 16'h8000 for padding
//   cmp_index           comparator running argmax, 1-based
//   cmp_largest         comparator running max
//   busy                run in progress
//   done                one-cycle completion pulse
//   result_index        final 1-based argmax, 0 = no winner
//   result_value        final maximum
//
// state  | meaning
// IDLE   | waiting for start; rejects bad counts with an immediate done
// CLEAR  | one cycle of comparator clear
// FETCH  | four read slots, one element per slot or a pad slot
// WAIT   | last read's data lands in cmp_in4
// TRIG   | comparator trigger with enable
// EVAL   | enable held, choose next group or finish
// FINISH | latch comparator outputs, pulse done next cycle

module argmax_feeder #(
   parameter int ADDR_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               num_vals,
   input  logic [ADDR_W-1:0]        base_addr,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic signed [15:0]       mem_rdata,
   output logic                     cmp_reset,
   output logic                     cmp_enable,
   output logic                     cmp_trig,
   output logic signed [15:0]       cmp_in1,
   output logic signed [15:0]       cmp_in2,
   output logic signed [15:0]       cmp_in3,
   output logic signed [15:0]       cmp_in4,
   input  logic [7:0]               cmp_index,
   input  logic signed [15:0]       cmp_largest,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               result_index,
   output logic signed [15:0]       result_value
);

   // Most-negative value: never beats the comparator's cleared maximum,
   // so pad slots cannot change the result.
   localparam logic signed [15:0] PAD_VAL = 16'sh8000;
   localparam logic [7:0]         MAX_NUM = 8'd252;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FETCH,
      ST_WAIT,
      ST_TRIG,
      ST_EVAL,
      ST_FINISH
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            num_q, num_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [7:0]            ptr_q, ptr_d;
   logic [1:0]            slot_q, slot_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [1:0]            cap_slot_q, cap_slot_d;
   logic                  cap_pad_q, cap_pad_d;
   logic signed [15:0]    cmp_in_q [4];
   logic signed [15:0]    cmp_in_d [4];
   logic                  done_q, done_d;
   logic [7:0]            res_idx_q, res_idx_d;
   logic signed [15:0]    res_val_q, res_val_d;

   logic                  rd_ok;
   logic                  num_ok;

   assign rd_ok  = (ptr_q < num_q);
   assign num_ok = (num_vals != 8'd0) && (num_vals <= MAX_NUM);

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      base_d     = base_q;
      ptr_d      = ptr_q;
      slot_d     = slot_q;
      cap_vld_d  = 1'b0;
      cap_slot_d = cap_slot_q;
      cap_pad_d  = cap_pad_q;
      for (int i = 0; i < 4; i++) begin
         cmp_in_d[i] = cmp_in_q[i];
      end
      done_d     = 1'b0;
      res_idx_d  = res_idx_q;
      res_val_d  = res_val_q;
      mem_rd     = 1'b0;
      mem_addr   = '0;

      // Read data arrives one cycle after its slot; steer it into the
      // operand register that slot owns.
      if (cap_vld_q) begin
         cmp_in_d[cap_slot_q] = cap_pad_q ? PAD_VAL : mem_rdata;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_ok) begin
                  num_d   = num_vals;
                  base_d  = base_addr;
                  ptr_d   = 8'd0;
                  slot_d  = 2'd0;
                  state_d = ST_CLEAR;
               end else begin
                  done_d    = 1'b1;
                  res_idx_d = 8'd0;
                  res_val_d = PAD_VAL;
               end
            end
         end
         ST_CLEAR: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            cap_vld_d  = 1'b1;
            cap_slot_d = slot_q;
            cap_pad_d  = !rd_ok;
            if (rd_ok) begin
               mem_rd   = 1'b1;
               mem_addr = base_q + ADDR_W'(ptr_q);
               ptr_d    = ptr_q + 8'd1;
            end
            // slot wraps 3 -> 0, ready for the next group
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            state_d = ST_TRIG;
         end
         ST_TRIG: begin
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            state_d = rd_ok ? ST_FETCH : ST_FINISH;
         end
         ST_FINISH: begin
            done_d    = 1'b1;
            res_idx_d = cmp_index;
            res_val_d = cmp_largest;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         num_q      <= 8'd0;
         base_q     <= '0;
         ptr_q      <= 8'd0;
         slot_q     <= 2'd0;
         cap_vld_q  <= 1'b0;
         cap_slot_q <= 2'd0;
         cap_pad_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cmp_in_q[i] <= PAD_VAL;
         end
         done_q     <= 1'b0;
         res_idx_q  <= 8'd0;
         res_val_q  <= PAD_VAL;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         base_q     <= base_d;
         ptr_q      <= ptr_d;
         slot_q     <= slot_d;
         cap_vld_q  <= cap_vld_d;
         cap_slot_q <= cap_slot_d;
         cap_pad_q  <= cap_pad_d;
         for (int i = 0; i < 4; i++) begin
            cmp_in_q[i] <= cmp_in_d[i];
         end
         done_q     <= done_d;
         res_idx_q  <= res_idx_d;
         res_val_q  <= res_val_d;
      end
   end

   // Clear is combinational on reset so the comparator is scrubbed in the
   // same cycle the feeder is.
   assign cmp_reset    = reset || (state_q == ST_CLEAR);
   assign cmp_trig     = (state_q == ST_TRIG);
   assign cmp_enable   = (state_q == ST_TRIG) || (state_q == ST_EVAL);
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign result_index = res_idx_q;
   assign result_value = res_val_q;
   assign cmp_in1      = cmp_in_q[0];
   assign cmp_in2      = cmp_in_q[1];
   assign cmp_in3      = cmp_in_q[2];
   assign cmp_in4      = cmp_in_q[3];

endmodule

// File: tb/tb_argmax_feeder.sv
module tb_argmax_feeder;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [7:0]        num_vals;
   logic [ADDR_W-1:0] base_addr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              cmp_reset;
   logic              cmp_enable;
   logic              cmp_trig;
   logic [15:0]       cmp_in1, cmp_in2, cmp_in3, cmp_in4;
   logic [7:0]        cmp_index;
   logic [15:0]       cmp_largest;
   logic              busy;
   logic              done;
   logic [7:0]        result_index;
   logic [15:0]       result_value;

   int n_chk = 0;
   int n_err = 0;

   argmax_feeder #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_vals     (num_vals),
      .base_addr    (base_addr),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .cmp_reset    (cmp_reset),
      .cmp_enable   (cmp_enable),
      .cmp_trig     (cmp_trig),
      .cmp_in1      (cmp_in1),
      .cmp_in2      (cmp_in2),
      .cmp_in3      (cmp_in3),
      .cmp_in4      (cmp_in4),
      .cmp_index    (cmp_index),
      .cmp_largest  (cmp_largest),
      .busy         (busy),
      .done         (done),
      .result_index (result_index),
      .result_value (result_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-cycle-latency buffer with a read log
   logic [15:0]       mem [0:255];
   logic [ADDR_W-1:0] rd_addrs [$];
   int                clr_cnt = 0;

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata <= mem[mem_addr];
         rd_addrs.push_back(mem_addr);
      end
      if (cmp_reset && !reset) clr_cnt++;
   end

   // Comparator: strict greater-than keeps the lowest index on ties and
   // never lets a 16'h8000 pad displace the cleared maximum.
   logic [15:0] c_max;
   logic [7:0]  c_idx;
   logic [7:0]  c_grp;
   assign cmp_index   = c_idx;
   assign cmp_largest = c_max;

   always @(posedge clk) begin
      logic [15:0] m;
      logic [7:0]  ix;
      logic [15:0] ops [4];
      if (cmp_reset) begin
         c_max <= 16'h8000;
         c_idx <= 8'd0;
         c_grp <= 8'd0;
      end else if (cmp_enable && cmp_trig) begin
         m = c_max;
         ix = c_idx;
         ops = '{cmp_in1, cmp_in2, cmp_in3, cmp_in4};
         for (int k = 0; k < 4; k++) begin
            if ($signed(ops[k]) > $signed(m)) begin
               m  = ops[k];
               ix = 8'(int'(c_grp) * 4 + k + 1);
            end
         end
         c_max <= m;
         c_idx <= ix;
         c_grp <= c_grp + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] a, input logic [15:0] v);
      mem[a] = v;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".busy"},      32'(busy),         32'd0);
      chk({tag, ".done"},      32'(done),         32'd0);
      chk({tag, ".mem_rd"},    32'(mem_rd),       32'd0);
      chk({tag, ".mem_addr"},  32'(mem_addr),     32'd0);
      chk({tag, ".trig"},      32'(cmp_trig),     32'd0);
      chk({tag, ".enable"},    32'(cmp_enable),   32'd0);
      chk({tag, ".in1"},       32'(cmp_in1),      32'h8000);
      chk({tag, ".in2"},       32'(cmp_in2),      32'h8000);
      chk({tag, ".in3"},       32'(cmp_in3),      32'h8000);
      chk({tag, ".in4"},       32'(cmp_in4),      32'h8000);
      chk({tag, ".res_idx"},   32'(result_index), 32'd0);
      chk({tag, ".res_val"},   32'(result_value), 32'h8000);
   endtask

   logic [15:0] last_in [4];

   // Launches one run and checks timing, read stream and result.
   // poke > 0 pulses start (with a different count) in that cycle.
   task automatic run(input string tag, input logic [7:0] num, input logic [7:0] base,
                      input logic [7:0] exp_idx, input logic [15:0] exp_val, input int poke);
      int   g, exp_done, done_at, done_cnt, busy_bad, en_bad, addr_bad, last;
      logic valid, b_exp, e_exp, t_exp;
      valid    = (num >= 8'd1) && (num <= 8'd252);
      g        = (int'(num) + 3) / 4;
      exp_done = valid ? 3 + 7 * g : 1;
      last     = 2 + 7 * g;
      done_at  = -1;
      done_cnt = 0;
      busy_bad = 0;
      en_bad   = 0;
      addr_bad = 0;
      @(negedge clk);
      rd_addrs.delete();
      clr_cnt   = 0;
      start     = 1'b1;
      num_vals  = num;
      base_addr = base;
      for (int c = 1; c <= exp_done + 3; c++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         b_exp = valid && c >= 1 && c <= last;
         e_exp = valid && c >= 7 && c <= last && ((c - 7) % 7 <= 1);
         t_exp = valid && c >= 7 && c <= last && ((c - 7) % 7 == 0);
         if (busy !== b_exp) busy_bad++;
         if (cmp_enable !== e_exp || cmp_trig !== t_exp) en_bad++;
         if (cmp_trig) last_in = '{cmp_in1, cmp_in2, cmp_in3, cmp_in4};
         start = (c == poke);
         if (c == poke) num_vals = 8'd1;
      end
      start = 1'b0;
      foreach (rd_addrs[i]) begin
         if (rd_addrs[i] !== 8'(base + 8'(i))) addr_bad++;
      end
      chk({tag, ".done_at"},  32'(done_at),         32'(exp_done));
      chk({tag, ".done_cnt"}, 32'(done_cnt),        32'd1);
      chk({tag, ".res_idx"},  32'(result_index),    32'(exp_idx));
      chk({tag, ".res_val"},  32'(result_value),    32'(exp_val));
      chk({tag, ".reads"},    32'(rd_addrs.size()), valid ? 32'(num) : 32'd0);
      chk({tag, ".addr_bad"}, 32'(addr_bad),        32'd0);
      chk({tag, ".clears"},   32'(clr_cnt),         valid ? 32'd1 : 32'd0);
      chk({tag, ".busy_bad"}, 32'(busy_bad),        32'd0);
      chk({tag, ".en_bad"},   32'(en_bad),          32'd0);
   endtask

   initial begin
      int dcnt, bcnt;
      reset     = 1'b1;
      start     = 1'b0;
      num_vals  = 8'd0;
      base_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("init");
      chk("init.cmp_reset", 32'(cmp_reset), 32'd1);
      reset = 1'b0;

      // single group, tie on 9 resolves to element 3
      put(8'h00, 16'd5); put(8'h01, 16'hFFFD); put(8'h02, 16'd9); put(8'h03, 16'd9);
      run("g1", 8'd4, 8'h00, 8'd3, 16'd9, 0);

      // two groups, second group half padded
      put(8'h10, 16'd1); put(8'h11, 16'd2); put(8'h12, 16'd3);
      put(8'h13, 16'd4); put(8'h14, 16'd7); put(8'h15, 16'd7);
      run("g2", 8'd6, 8'h10, 8'd5, 16'd7, 0);
      chk("g2.in1", 32'(last_in[0]), 32'd7);
      chk("g2.in2", 32'(last_in[1]), 32'd7);
      chk("g2.pad3", 32'(last_in[2]), 32'h8000);
      chk("g2.pad4", 32'(last_in[3]), 32'h8000);

      // rejected counts
      run("num0",   8'd0,   8'h00, 8'd0, 16'h8000, 0);
      run("num253", 8'd253, 8'h00, 8'd0, 16'h8000, 0);

      // address wrap FE, FF, 00, 01
      put(8'hFE, 16'hFFFF); put(8'hFF, 16'd100); put(8'h00, 16'd3); put(8'h01, 16'd100);
      run("wrap", 8'd4, 8'hFE, 8'd2, 16'd100, 0);

      // all pad-valued data: no winner
      put(8'h20, 16'h8000); put(8'h21, 16'h8000); put(8'h22, 16'h8000);
      run("allmin", 8'd3, 8'h20, 8'd0, 16'h8000, 0);

      // start while busy is ignored
      put(8'h40, 16'd1); put(8'h41, 16'd1); put(8'h42, 16'd1); put(8'h43, 16'd1);
      put(8'h44, 16'd2); put(8'h45, 16'd1); put(8'h46, 16'd1); put(8'h47, 16'd1);
      put(8'h48, 16'hFFFB);
      run("poke", 8'd9, 8'h40, 8'd5, 16'd2, 4);

      // reset in EVAL of the first group
      for (int i = 0; i < 8; i++) put(8'(8'h30 + i), 16'(50 + i));
      @(negedge clk);
      start     = 1'b1;
      num_vals  = 8'd8;
      base_addr = 8'h30;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("rst.in_eval", {30'd0, cmp_enable, cmp_trig}, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("rst");
      chk("rst.cmp_reset_hi", 32'(cmp_reset), 32'd1);
      reset = 1'b0;
      #1;
      chk("rst.cmp_reset_lo", 32'(cmp_reset), 32'd0);
      dcnt = 0;
      bcnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) dcnt++;
         if (busy) bcnt++;
      end
      chk("rst.no_done", 32'(dcnt), 32'd0);
      chk("rst.no_busy", 32'(bcnt), 32'd0);

      // clean run after the abort
      put(8'h60, 16'hFFF6); put(8'h61, 16'hFFEC); put(8'h62, 16'hFFE2);
      put(8'h63, 16'hFFD8); put(8'h64, 16'hFFF7);
      run("post_rst", 8'd5, 8'h60, 8'd5, 16'hFFF7, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/argmax_feeder.md
ARGMAX_FEEDER -- requirements
Module: argmax_feeder

Interface
REQ-001 SHALL have parameter: ADDR_W, default 8, result-buffer address width.
REQ-002 SHALL have ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- num_vals  in  8  element count for the run, valid 1..252.
- base_addr  in  ADDR_W  address of element 1.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  16  signed read data, valid the cycle after mem_rd.
- cmp_reset  out  1  comparator clear.
- cmp_enable  out  1  comparator enable.
- cmp_trig  out  1  comparator trigger.
- cmp_in1..cmp_in4  out  16 each  signed comparator operands.
- cmp_index  in  8  comparator running argmax, 1-based.
- cmp_largest  in  16  comparator running max.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- result_index  out  8  final 1-based argmax; 0 means no winner.
- result_value  out  16  final maximum.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, FETCH, WAIT, TRIG, EVAL, FINISH.
REQ-004 IDLE SHALL be left on start=1 with 1<=num_vals<=252: latch num_vals and base_addr, clear element pointer, go to CLEAR.
REQ-005 In IDLE, start=1 with num_vals=0 or >252 SHALL give, at the next edge:
- done=1 for one cycle, result_index=0, result_value=16'h8000;
- no mem_rd and no cmp_reset; FSM stays in IDLE.
REQ-006 start SHALL be ignored in every state except IDLE.
REQ-007 CLEAR SHALL last one cycle with cmp_reset=1, then go to FETCH.
REQ-008 FETCH SHALL last 4 cycles, slot k=0..3, each cycle as follows:
- ptr<num: mem_rd=1, mem_addr=(base_addr+ptr) mod 2^ADDR_W, ptr increments;
- otherwise: mem_rd=0 and the slot is marked as pad.
REQ-009 Read data SHALL be captured into cmp_in(k+1) the cycle after the slot k read; pad slots load 16'h8000.
REQ-010 WAIT SHALL last one cycle, capturing slot 3, then go to TRIG.
REQ-011 TRIG SHALL last one cycle with cmp_trig=1 and cmp_enable=1, then go to EVAL.
REQ-012 EVAL SHALL last one cycle with cmp_trig=0 and cmp_enable=1, then:
- ptr<num: go to FETCH;
- otherwise: go to FINISH.
REQ-013 cmp_in1..4 SHALL stay stable from the first TRIG cycle through the end of EVAL.
REQ-014 cmp_enable SHALL be 0 in all states other than TRIG and EVAL.
REQ-015 FINISH SHALL last one cycle; at its closing edge it SHALL load result_index<=cmp_index and result_value<=cmp_largest, set done=1 for the next cycle only, and go to IDLE.
REQ-016 Timing, with G=ceil(num_vals/4) and the start cycle as cycle 0:
- busy=1 in cycles 1..2+7G;
- done=1 in cycle 3+7G;
- mem_rd asserted exactly num_vals times, addresses in ascending element order.
REQ-017 result_* SHALL hold until the next done; a start in the done cycle SHALL be accepted.
REQ-018 Element n SHALL be presented on cmp_in(((n-1) mod 4)+1) in group ceil(n/4). Ties resolve to the lowest index.
REQ-019 Padding with 16'h8000 SHALL never change the result.

Reset
REQ-020 Reset, including reset mid-run, SHALL return the FSM to IDLE at the next edge with no done, and SHALL set:
- busy=0, done=0, mem_rd=0, mem_addr=0;
- cmp_trig=0, cmp_enable=0, cmp_in1..4=16'h8000;
- result_index=0, result_value=16'h8000.
REQ-021 cmp_reset SHALL equal reset OR (state==CLEAR).

Verification
REQ-022 The bench SHALL use a 1-cycle-latency memory model plus the existing comparator, and SHALL cover these scenarios:
- num=4, base=0, data {5,-3,9,9} -> done at cycle 10, result_index=3, result_value=9, 4 reads.
- num=6, data {1,2,3,4,7,7} -> G=2, done at cycle 17, result_index=5, result_value=7, exactly 6 reads, slots 3-4 of group 2 hold 16'h8000.
- num=0, then num=253 -> done the cycle after start, result_index=0, result_value=16'h8000, no mem_rd, no cmp_reset.
- num=4, base=2^ADDR_W-2 -> addresses FE, FF, 00, 01.
- num=3, all data 16'h8000 -> result_index=0, result_value=16'h8000.
- start pulsed while busy -> ignored.
- reset asserted in EVAL -> IDLE next cycle, all outputs at reset values, no done; a new run then completes correctly.
